// File: rtl/branch_resolve_pipe.sv
// Registered branch/JAL/JALR resolution stage with valid/ready output handshake.
// Optional saturating statistics counters are compiled in when BR_STATS_EN is defined.
module branch_resolve_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       fun3,
  input  logic [XLEN-1:0]  rdata1,
  input  logic [XLEN-1:0]  rdata2,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             br_taken,
  output logic [XLEN-1:0]  br_target,
  output logic             mispredict,
  output logic             misalign,
  output logic             is_cf,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_mispred
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic            accept;
  logic            is_branch, is_jal, is_jalr;
  logic            cond_taken, taken_c, cf_c, mispred_c, misalign_c;
  logic [XLEN-1:0] sum_c, jump_target_c, target_c;

  logic            out_valid_reg, br_taken_reg, mispredict_reg, misalign_reg, is_cf_reg;
  logic [XLEN-1:0] br_target_reg;

  assign in_ready = !out_valid_reg | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    is_branch  = (opcode == OP_BRANCH);
    is_jal     = (opcode == OP_JAL);
    is_jalr    = (opcode == OP_JALR);
    cond_taken = 1'b0;
    case (fun3)
      3'b000:  cond_taken = (rdata1 == rdata2);
      3'b001:  cond_taken = (rdata1 != rdata2);
      3'b100:  cond_taken = ($signed(rdata1) <  $signed(rdata2));
      3'b101:  cond_taken = ($signed(rdata1) >= $signed(rdata2));
      3'b110:  cond_taken = (rdata1 <  rdata2);
      3'b111:  cond_taken = (rdata1 >= rdata2);
      default: cond_taken = 1'b0;
    endcase
    taken_c = (is_branch & cond_taken) | is_jal | is_jalr;
    cf_c    = is_branch | is_jal | is_jalr;
    // JALR adds to rs1 and drops bit 0; branches and JAL are PC-relative
    sum_c         = (is_jalr ? rdata1 : pc) + imm;
    jump_target_c = is_jalr ? {sum_c[XLEN-1:1], 1'b0} : sum_c;
    target_c      = taken_c ? jump_target_c : pc + XLEN'(4);
    mispred_c     = cf_c & (taken_c != pred_taken);
    misalign_c    = taken_c & (target_c[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg  <= 1'b0;
      br_taken_reg   <= 1'b0;
      br_target_reg  <= '0;
      mispredict_reg <= 1'b0;
      misalign_reg   <= 1'b0;
      is_cf_reg      <= 1'b0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
    end else if (accept) begin
      out_valid_reg  <= 1'b1;
      br_taken_reg   <= taken_c;
      br_target_reg  <= target_c;
      mispredict_reg <= mispred_c;
      misalign_reg   <= misalign_c;
      is_cf_reg      <= cf_c;
    end else if (out_ready) begin
      out_valid_reg  <= 1'b0;
    end
  end

  assign out_valid  = out_valid_reg;
  assign br_taken   = br_taken_reg;
  assign br_target  = br_target_reg;
  assign mispredict = mispredict_reg;
  assign misalign   = misalign_reg;
  assign is_cf      = is_cf_reg;

`ifdef BR_STATS_EN
  logic [2:0]         cnt_hit;
  logic [3*CNT_W-1:0] cnt_all;

  assign cnt_hit = {mispred_c, taken_c, cf_c};

  // Slot 0 = control-flow ops, 1 = taken, 2 = mispredicts
  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        cnt_reg <= '0;
      else if (accept && !flush && cnt_hit[gi] && (cnt_reg != '1))
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
    assign cnt_all[gi*CNT_W +: CNT_W] = cnt_reg;
  end

  assign cnt_branch  = cnt_all[0*CNT_W +: CNT_W];
  assign cnt_taken   = cnt_all[1*CNT_W +: CNT_W];
  assign cnt_mispred = cnt_all[2*CNT_W +: CNT_W];
`else
  assign cnt_branch  = '0;
  assign cnt_taken   = '0;
  assign cnt_mispred = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Directed bench for branch_resolve_pipe: decode, targets, handshake, flush, stats and async reset.
module tb_branch_resolve_pipe;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_ALU = 7'b0110011;
`ifdef BR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [6:0]       opcode;
  logic [2:0]       fun3;
  logic [XLEN-1:0]  rdata1, rdata2, pc, imm;
  logic             pred_taken, flush;
  logic             out_valid, out_ready;
  logic             br_taken, mispredict, misalign, is_cf;
  logic [XLEN-1:0]  br_target;
  logic [CNT_W-1:0] cnt_branch, cnt_taken, cnt_mispred;

  int checks = 0;
  int errors = 0;
  int exp_b = 0, exp_t = 0, exp_m = 0;

  branch_resolve_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .fun3(fun3), .rdata1(rdata1), .rdata2(rdata2),
    .pc(pc), .imm(imm), .pred_taken(pred_taken), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .br_taken(br_taken),
    .br_target(br_target), .mispredict(mispredict), .misalign(misalign),
    .is_cf(is_cf), .cnt_branch(cnt_branch), .cnt_taken(cnt_taken),
    .cnt_mispred(cnt_mispred)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v < (1 << CNT_W) - 1) ? v + 1 : v;
  endfunction

  // Reference model of the statistics counters
  task automatic note_accept(input bit cf, input bit tk, input bit mp);
    if (cf) exp_b = sat(exp_b);
    if (tk) exp_t = sat(exp_t);
    if (mp) exp_m = sat(exp_m);
  endtask

  task automatic set_req(input logic [6:0] op, input logic [2:0] f3,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] p, input logic [XLEN-1:0] i,
                         input logic pr);
    opcode = op; fun3 = f3; rdata1 = a; rdata2 = b; pc = p; imm = i;
    pred_taken = pr; in_valid = 1'b1;
  endtask

  // Single request with out_ready=1; leaves the result visible at the following negedge
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] p, input logic [XLEN-1:0] i,
                        input logic pr);
    @(negedge clk);
    set_req(op, f3, a, b, p, i, pr);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    set_req(7'd0, 3'd0, '0, '0, '0, '0, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, br_taken, mispredict, misalign, is_cf} !== 5'b0 || br_target !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b t=%b tgt=%h mp=%b ma=%b cf=%b want all 0",
               out_valid, br_taken, br_target, mispredict, misalign, is_cf);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if ({cnt_branch, cnt_taken, cnt_mispred} !== '0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0",
                         cnt_branch, cnt_taken, cnt_mispred);
    end
  endtask

  task automatic test_branch_decode();
    // BGE equal operands, predicted not taken
    run_op(OP_BR, 3'b101, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    note_accept(1, 1, 1);
    checks++;
    if ({out_valid, br_taken, mispredict, misalign, is_cf} !== 5'b11101 || br_target !== 32'h120) begin
      errors++;
      $display("FAIL bge: got v/t/mp/ma/cf=%b%b%b%b%b tgt=%h want 11101 tgt=00000120",
               out_valid, br_taken, mispredict, misalign, is_cf, br_target);
    end
    checks++;
    if (cnt_branch !== CNT_W'(STATS ? exp_b : 0) || cnt_taken !== CNT_W'(STATS ? exp_t : 0) ||
        cnt_mispred !== CNT_W'(STATS ? exp_m : 0)) begin
      errors++;
      $display("FAIL cnt_after_bge: got %0d/%0d/%0d want %0d/%0d/%0d", cnt_branch, cnt_taken,
               cnt_mispred, STATS ? exp_b : 0, STATS ? exp_t : 0, STATS ? exp_m : 0);
    end
    // BLTU: 0xFFFFFFFF is not below 1 unsigned
    run_op(OP_BR, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b0);
    note_accept(1, 0, 0);
    checks++;
    if ({out_valid, br_taken, mispredict, misalign, is_cf} !== 5'b10001 || br_target !== 32'h204) begin
      errors++;
      $display("FAIL bltu: got v/t/mp/ma/cf=%b%b%b%b%b tgt=%h want 10001 tgt=00000204",
               out_valid, br_taken, mispredict, misalign, is_cf, br_target);
    end
    // BLT: -1 < 1 signed
    run_op(OP_BR, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b1);
    note_accept(1, 1, 0);
    checks++;
    if ({out_valid, br_taken, mispredict, misalign, is_cf} !== 5'b11001 || br_target !== 32'h210) begin
      errors++;
      $display("FAIL blt: got v/t/mp/ma/cf=%b%b%b%b%b tgt=%h want 11001 tgt=00000210",
               out_valid, br_taken, mispredict, misalign, is_cf, br_target);
    end
    // BEQ unequal, predicted taken -> mispredict
    run_op(OP_BR, 3'b000, 32'd3, 32'd4, 32'h300, 32'h40, 1'b1);
    note_accept(1, 0, 1);
    checks++;
    if ({out_valid, br_taken, mispredict, misalign, is_cf} !== 5'b10101 || br_target !== 32'h304) begin
      errors++;
      $display("FAIL beq_nt: got v/t/mp/ma/cf=%b%b%b%b%b tgt=%h want 10101 tgt=00000304",
               out_valid, br_taken, mispredict, misalign, is_cf, br_target);
    end
    // BNE taken to a halfword-aligned target -> misalign
    run_op(OP_BR, 3'b001, 32'd3, 32'd4, 32'h100, 32'h6, 1'b1);
    note_accept(1, 1, 0);
    checks++;
    if ({out_valid, br_taken, mispredict, misalign, is_cf} !== 5'b11011 || br_target !== 32'h106) begin
      errors++;
      $display("FAIL bne_misalign: got v/t/mp/ma/cf=%b%b%b%b%b tgt=%h want 11011 tgt=00000106",
               out_valid, br_taken, mispredict, misalign, is_cf, br_target);
    end
    // Reserved fun3 010 never taken, even when operands match
    run_op(OP_BR, 3'b010, 32'd9, 32'd9, 32'h400, 32'h8, 1'b1);
    note_accept(1, 0, 1);
    checks++;
    if ({out_valid, br_taken, mispredict, misalign, is_cf} !== 5'b10101 || br_target !== 32'h404) begin
      errors++;
      $display("FAIL fun3_010: got v/t/mp/ma/cf=%b%b%b%b%b tgt=%h want 10101 tgt=00000404",
               out_valid, br_taken, mispredict, misalign, is_cf, br_target);
    end
    // BGEU: 1 >= 0xFFFFFFFF unsigned is false
    run_op(OP_BR, 3'b111, 32'd1, 32'hFFFF_FFFF, 32'h500, 32'h8, 1'b0);
    note_accept(1, 0, 0);
    checks++;
    if ({out_valid, br_taken, mispredict, misalign, is_cf} !== 5'b10001 || br_target !== 32'h504) begin
      errors++;
      $display("FAIL bgeu: got v/t/mp/ma/cf=%b%b%b%b%b tgt=%h want 10001 tgt=00000504",
               out_valid, br_taken, mispredict, misalign, is_cf, br_target);
    end
  endtask

  task automatic test_jumps();
    run_op(OP_JR, 3'b000, 32'h1003, 32'd0, 32'h80, 32'h0, 1'b1);
    note_accept(1, 1, 0);
    checks++;
    if ({out_valid, br_taken, mispredict, misalign, is_cf} !== 5'b11011 || br_target !== 32'h1002) begin
      errors++;
      $display("FAIL jalr: got v/t/mp/ma/cf=%b%b%b%b%b tgt=%h want 11011 tgt=00001002",
               out_valid, br_taken, mispredict, misalign, is_cf, br_target);
    end
    // PC-relative wrap-around
    run_op(OP_JAL, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h8, 1'b0);
    note_accept(1, 1, 1);
    checks++;
    if ({out_valid, br_taken, mispredict, misalign, is_cf} !== 5'b11101 || br_target !== 32'h4) begin
      errors++;
      $display("FAIL jal_wrap: got v/t/mp/ma/cf=%b%b%b%b%b tgt=%h want 11101 tgt=00000004",
               out_valid, br_taken, mispredict, misalign, is_cf, br_target);
    end
    // Non-control-flow op passes through with pc+4
    run_op(OP_ALU, 3'b000, 32'd1, 32'd1, 32'h600, 32'h40, 1'b1);
    checks++;
    if ({out_valid, br_taken, mispredict, misalign, is_cf} !== 5'b10000 || br_target !== 32'h604) begin
      errors++;
      $display("FAIL non_cf: got v/t/mp/ma/cf=%b%b%b%b%b tgt=%h want 10000 tgt=00000604",
               out_valid, br_taken, mispredict, misalign, is_cf, br_target);
    end
    checks++;
    if (cnt_branch !== CNT_W'(STATS ? exp_b : 0) || cnt_taken !== CNT_W'(STATS ? exp_t : 0) ||
        cnt_mispred !== CNT_W'(STATS ? exp_m : 0)) begin
      errors++;
      $display("FAIL cnt_after_jumps: got %0d/%0d/%0d want %0d/%0d/%0d", cnt_branch, cnt_taken,
               cnt_mispred, STATS ? exp_b : 0, STATS ? exp_t : 0, STATS ? exp_m : 0);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b0;
    set_req(OP_BR, 3'b000, 32'd7, 32'd7, 32'h300, 32'h40, 1'b0);
    @(negedge clk);
    note_accept(1, 1, 1);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || br_target !== 32'h340) begin
      errors++;
      $display("FAIL b2b_first: got v=%b rdy=%b tgt=%h want v=1 rdy=0 tgt=00000340",
               out_valid, in_ready, br_target);
    end
    set_req(OP_BR, 3'b001, 32'd7, 32'd7, 32'h400, 32'h40, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || br_target !== 32'h340 || br_taken !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold: got v=%b rdy=%b tgt=%h t=%b want v=1 rdy=0 tgt=00000340 t=1",
               out_valid, in_ready, br_target, br_taken);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready_path: got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    note_accept(1, 0, 0);
    checks++;
    if ({out_valid, br_taken, mispredict, is_cf} !== 4'b1001 || br_target !== 32'h404) begin
      errors++;
      $display("FAIL b2b_second: got v/t/mp/cf=%b%b%b%b tgt=%h want 1001 tgt=00000404",
               out_valid, br_taken, mispredict, is_cf, br_target);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    set_req(OP_JAL, 3'b000, '0, '0, 32'h700, 32'h10, 1'b0);
    out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_accept: got v=%b want 0", out_valid);
    end
    checks++;
    if (cnt_branch !== CNT_W'(STATS ? exp_b : 0) || cnt_taken !== CNT_W'(STATS ? exp_t : 0) ||
        cnt_mispred !== CNT_W'(STATS ? exp_m : 0)) begin
      errors++;
      $display("FAIL flush_counters: got %0d/%0d/%0d want %0d/%0d/%0d", cnt_branch, cnt_taken,
               cnt_mispred, STATS ? exp_b : 0, STATS ? exp_t : 0, STATS ? exp_m : 0);
    end
    // Flush a held result while the consumer is stalled
    set_req(OP_JAL, 3'b000, '0, '0, 32'h700, 32'h10, 1'b1);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    note_accept(1, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || br_target !== 32'h710) begin
      errors++; $display("FAIL flush_pre_hold: got v=%b tgt=%h want v=1 tgt=00000710",
                         out_valid, br_target);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_held: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_stats_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_b = 0; exp_t = 0; exp_m = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      run_op(OP_JAL, 3'b000, '0, '0, 32'h800, 32'h20, 1'b1);
      note_accept(1, 1, 0);
      checks++;
      if (cnt_taken !== CNT_W'(STATS ? exp_t : 0) || cnt_branch !== CNT_W'(STATS ? exp_b : 0)) begin
        errors++;
        $display("FAIL sat_jal%0d: got taken=%0d branch=%0d want %0d/%0d", k, cnt_taken,
                 cnt_branch, STATS ? exp_t : 0, STATS ? exp_b : 0);
      end
    end
    // Async reset drops a held result and clears counters without a clock edge
    @(negedge clk);
    set_req(OP_JAL, 3'b000, '0, '0, 32'h900, 32'h4, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || br_taken !== 1'b0 || br_target !== '0 ||
        {cnt_branch, cnt_taken, cnt_mispred} !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b t=%b tgt=%h cnt=%0d/%0d/%0d want all 0", out_valid,
               br_taken, br_target, cnt_branch, cnt_taken, cnt_mispred);
    end
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_branch_decode();
    test_jumps();
    test_back_to_back();
    test_flush();
    test_stats_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
